fourth_step: RTL and testbench

// - MEM stage of the 5-stage MIPS pipeline. Consumer end of the execute-stage outputs.
// - Latches the EX results into an internal EX/MEM register.
// - Resolves the branch (pcSrc/branchTarget), performs the data-memory load/store,
//   and presents MEM/WB register outputs to the writeback stage.
// - Includes a word-addressed synchronous data RAM. No external memory interface.

---
 rtl/fourth_step.sv | 152 +++++++++++++++
 tb/tb_fourth_step.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fourth_step.sv
// fourth_step: MEM stage -- EX/MEM latch, branch resolve, data RAM,
// MEM/WB latch. Ports: clk/reset/stall/flush, EX controls+data in, WB out.
module fourth_step #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              branch,
  input  logic              regWrite,
  input  logic              memToReg,
  input  logic [DATA_W-1:0] addResult,
  input  logic              zero,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] reg2Out,
  input  logic [4:0]        muxRegDstOut,
  output logic              pcSrc,
  output logic [DATA_W-1:0] branchTarget,
  output logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] aluResultWb,
  output logic [4:0]        regDstWb,
  output logic              regWriteWb,
  output logic              memToRegWb
);

  localparam int DEPTH = 2 ** ADDR_W;

  // EX/MEM register
  logic              memRead_q, memRead_d;
  logic              memWrite_q, memWrite_d;
  logic              branch_q, branch_d;
  logic              regWrite_q, regWrite_d;
  logic              memToReg_q, memToReg_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] addResult_q, addResult_d;
  logic [DATA_W-1:0] aluResult_q, aluResult_d;
  logic [DATA_W-1:0] reg2Out_q, reg2Out_d;
  logic [4:0]        regDst_q, regDst_d;

  // MEM/WB register
  logic [DATA_W-1:0] memData_q;
  logic [DATA_W-1:0] aluWb_q;
  logic [4:0]        dstWb_q;
  logic              rwWb_q;
  logic              m2rWb_q;

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              we;

  // Byte address -> word index; low bits and high bits dropped.
  assign idx = aluResult_q[ADDR_W+1:2];
  // Reset gate keeps a latched store from committing on a reset edge.
  assign we  = memWrite_q & ~stall & ~reset;

  // Flush beats stall: a bubble replaces whatever is held.
  always_comb begin
    memRead_d   = memRead_q;
    memWrite_d  = memWrite_q;
    branch_d    = branch_q;
    regWrite_d  = regWrite_q;
    memToReg_d  = memToReg_q;
    zero_d      = zero_q;
    addResult_d = addResult_q;
    aluResult_d = aluResult_q;
    reg2Out_d   = reg2Out_q;
    regDst_d    = regDst_q;
    if (flush) begin
      memRead_d  = 1'b0;
      memWrite_d = 1'b0;
      branch_d   = 1'b0;
      regWrite_d = 1'b0;
      memToReg_d = 1'b0;
    end else if (!stall) begin
      memRead_d   = memRead;
      memWrite_d  = memWrite;
      branch_d    = branch;
      regWrite_d  = regWrite;
      memToReg_d  = memToReg;
      zero_d      = zero;
      addResult_d = addResult;
      aluResult_d = aluResult;
      reg2Out_d   = reg2Out;
      regDst_d    = muxRegDstOut;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      regWrite_q  <= 1'b0;
      memToReg_q  <= 1'b0;
      zero_q      <= 1'b0;
      addResult_q <= '0;
      aluResult_q <= '0;
      reg2Out_q   <= '0;
      regDst_q    <= '0;
    end else begin
      memRead_q   <= memRead_d;
      memWrite_q  <= memWrite_d;
      branch_q    <= branch_d;
      regWrite_q  <= regWrite_d;
      memToReg_q  <= memToReg_d;
      zero_q      <= zero_d;
      addResult_q <= addResult_d;
      aluResult_q <= aluResult_d;
      reg2Out_q   <= reg2Out_d;
      regDst_q    <= regDst_d;
    end
  end

  // MEM/WB; memData reads the pre-write word and only moves on loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memData_q <= '0;
      aluWb_q   <= '0;
      dstWb_q   <= '0;
      rwWb_q    <= 1'b0;
      m2rWb_q   <= 1'b0;
    end else if (!stall) begin
      if (memRead_q) begin
        memData_q <= ram_q[idx];
      end
      aluWb_q <= aluResult_q;
      dstWb_q <= regDst_q;
      rwWb_q  <= regWrite_q;
      m2rWb_q <= memToReg_q;
    end
  end

  // Data RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      ram_q[idx] <= reg2Out_q;
    end
  end

  assign pcSrc        = branch_q & zero_q;
  assign branchTarget = addResult_q;
  assign memData      = memData_q;
  assign aluResultWb  = aluWb_q;
  assign regDstWb     = dstWb_q;
  assign regWriteWb   = rwWb_q;
  assign memToRegWb   = m2rWb_q;

endmodule

// File: tb/tb_fourth_step.sv
// tb_fourth_step: directed vector table plus hand sequences
// for reset, stall and flush corner cases of fourth_step.
module tb_fourth_step;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        memRead, memWrite, branch;
  logic        regWrite, memToReg, zero;
  logic [31:0] addResult, aluResult, reg2Out;
  logic [4:0]  muxRegDstOut;
  logic        pcSrc;
  logic [31:0] branchTarget, memData, aluResultWb;
  logic [4:0]  regDstWb;
  logic        regWriteWb, memToRegWb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fourth_step dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .memRead(memRead), .memWrite(memWrite), .branch(branch),
    .regWrite(regWrite), .memToReg(memToReg),
    .addResult(addResult), .zero(zero), .aluResult(aluResult),
    .reg2Out(reg2Out), .muxRegDstOut(muxRegDstOut),
    .pcSrc(pcSrc), .branchTarget(branchTarget),
    .memData(memData), .aluResultWb(aluResultWb),
    .regDstWb(regDstWb), .regWriteWb(regWriteWb),
    .memToRegWb(memToRegWb)
  );

  typedef struct {
    logic        st, fl, mr, mw, br, rw, m2r, z;
    logic [31:0] add, alu, r2;
    logic [4:0]  dst;
    logic        e_pc;
    logic [31:0] e_bt, e_md, e_alu;
    logic [4:0]  e_dst;
    logic        e_rw, e_m2r;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic mr, input logic mw, input logic br,
                     input logic rw, input logic m2r, input logic z,
                     input logic [31:0] add, input logic [31:0] alu,
                     input logic [31:0] r2, input logic [4:0] dst);
    memRead = mr; memWrite = mw; branch = br;
    regWrite = rw; memToReg = m2r; zero = z;
    addResult = add; aluResult = alu;
    reg2Out = r2; muxRegDstOut = dst;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".pcSrc"}, {31'd0, pcSrc}, 0);
    chk({nm, ".bt"}, branchTarget, 0);
    chk({nm, ".memData"}, memData, 0);
    chk({nm, ".aluWb"}, aluResultWb, 0);
    chk({nm, ".dstWb"}, {27'd0, regDstWb}, 0);
    chk({nm, ".rwWb"}, {31'd0, regWriteWb}, 0);
    chk({nm, ".m2rWb"}, {31'd0, memToRegWb}, 0);
  endtask

  initial begin
    // st fl mr mw br rw m2r z  add alu r2 dst | pc bt md alu dst rw m2r
    vt[0]  = '{0,0,0,1,0,0,0,0, 0,'h10,'hDEADBEEF,0,
               0,0,0,0,0,0,0};
    vt[1]  = '{0,0,1,0,0,1,1,0, 0,'h10,0,5,
               0,0,0,'h10,0,0,0};
    vt[2]  = '{0,0,0,0,1,0,0,1, 'h40,0,0,0,
               1,'h40,'hDEADBEEF,'h10,5,1,1};
    vt[3]  = '{0,0,0,0,1,0,0,0, 'h40,0,0,0,
               0,'h40,'hDEADBEEF,0,0,0,0};
    vt[4]  = '{0,0,0,1,0,0,0,0, 0,'h200,'h1234,0,
               0,0,'hDEADBEEF,0,0,0,0};
    vt[5]  = '{0,0,1,0,0,1,1,0, 0,'h3,0,7,
               0,0,'hDEADBEEF,'h200,0,0,0};
    vt[6]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,
               0,0,'h1234,'h3,7,1,1};
    vt[7]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,
               0,0,'h1234,0,0,0,0};
    vt[8]  = '{0,0,1,1,0,1,0,0, 0,'h10,'hCAFE,9,
               0,0,'h1234,0,0,0,0};
    vt[9]  = '{0,0,1,0,0,1,1,0, 0,'h10,0,10,
               0,0,'hDEADBEEF,'h10,9,1,0};
    vt[10] = '{0,0,0,0,0,0,0,0, 0,0,0,0,
               0,0,'hCAFE,'h10,10,1,1};

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    nop();
    #12;
    chk_zero("rst");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      stall = vt[i].st; flush = vt[i].fl;
      drv(vt[i].mr, vt[i].mw, vt[i].br, vt[i].rw, vt[i].m2r,
          vt[i].z, vt[i].add, vt[i].alu, vt[i].r2, vt[i].dst);
      step();
      chk($sformatf("v%0d.pc", i), {31'd0, pcSrc}, {31'd0, vt[i].e_pc});
      chk($sformatf("v%0d.bt", i), branchTarget, vt[i].e_bt);
      chk($sformatf("v%0d.md", i), memData, vt[i].e_md);
      chk($sformatf("v%0d.alu", i), aluResultWb, vt[i].e_alu);
      chk($sformatf("v%0d.dst", i), {27'd0, regDstWb},
          {27'd0, vt[i].e_dst});
      chk($sformatf("v%0d.rw", i), {31'd0, regWriteWb},
          {31'd0, vt[i].e_rw});
      chk($sformatf("v%0d.m2r", i), {31'd0, memToRegWb},
          {31'd0, vt[i].e_m2r});
    end

    // Async reset between edges with live outputs.
    nop();
    #3;
    reset = 1'b1;
    #1;
    chk_zero("arst");
    step();
    reset = 1'b0;

    // Reset discards a latched, uncommitted store.
    drv(0, 1, 0, 0, 0, 0, 0, 'h30, 'h111, 0);
    step();
    nop();
    step();
    drv(0, 1, 0, 0, 0, 0, 0, 'h30, 'h777, 0);
    step();
    #2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    drv(1, 0, 0, 1, 1, 0, 0, 'h30, 0, 2);
    step();
    nop();
    step();
    chk("rstdrop.md", memData, 'h111);

    // Stall over a store.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drv(0, 1, 0, 0, 0, 0, 0, 'h8, 'hA5, 0);
    step();
    stall = 1'b1;
    drv(1, 0, 0, 1, 1, 0, 0, 'h8, 0, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stl%0d.alu", i), aluResultWb, 0);
      chk($sformatf("stl%0d.rw", i), {31'd0, regWriteWb}, 0);
    end
    stall = 1'b0;
    step();
    chk("stl.rel.alu", aluResultWb, 'h8);
    chk("stl.rel.rw", {31'd0, regWriteWb}, 0);
    nop();
    step();
    chk("stl.ld.md", memData, 'hA5);
    chk("stl.ld.dst", {27'd0, regDstWb}, 3);
    chk("stl.ld.rw", {31'd0, regWriteWb}, 1);

    // Flush beats stall; held store is dropped.
    drv(0, 1, 0, 0, 0, 0, 0, 'hC, 'h42, 0);
    step();
    nop();
    step();
    drv(0, 1, 0, 0, 0, 0, 0, 'hC, 'h99, 0);
    step();
    stall = 1'b1; flush = 1'b1;
    drv(0, 0, 0, 1, 0, 0, 0, 'h77, 0, 4);
    step();
    chk("fl.pc", {31'd0, pcSrc}, 0);
    chk("fl.hold.alu", aluResultWb, 0);
    stall = 1'b0; flush = 1'b0;
    nop();
    step();
    chk("fl.rw", {31'd0, regWriteWb}, 0);
    chk("fl.m2r", {31'd0, memToRegWb}, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 'hC, 0, 0);
    step();
    nop();
    step();
    chk("fl.md", memData, 'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
